gray_counter: RTL and testbench

//  Parametrised synchronous up/down counter with registered binary and Gray-code outputs.

---
 rtl/gray_counter.sv | 95 +++++++++
 tb/tb_gray_counter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// gray_counter: synchronous up/down counter with registered binary and Gray outputs.
// Supports enable, direction, parallel load, wrap or saturate at the limits, and a
// registered terminal-count flag. Defining GRAY_CNT_CHECK_EN adds the err output and a
// sticky Gray single-step checker.
module gray_counter #(
  parameter int unsigned N        = 4,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned RST_VAL  = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up_dn,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] bin_out,
  output logic [N-1:0] gray_out,
  output logic         tc
`ifdef GRAY_CNT_CHECK_EN
  ,
  output logic         err
`endif
);

  localparam logic [N-1:0] ONE     = N'(1);
  localparam logic [N-1:0] RST_BIN = N'(RST_VAL);

  function automatic logic [N-1:0] to_gray(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [N-1:0] bin_next;
  logic         tc_next;
  logic         at_limit;

  // Next count and terminal-count for an enabled step in the current direction
  always_comb begin
    bin_next = bin_out;
    tc_next  = 1'b0;
    at_limit = up_dn ? (&bin_out) : ~(|bin_out);
    if (SATURATE && at_limit) begin
      bin_next = bin_out;
      tc_next  = 1'b1;
    end else begin
      bin_next = up_dn ? (bin_out + ONE) : (bin_out - ONE);
      tc_next  = at_limit;
    end
  end

  // Counter registers: rst > load > en, otherwise everything holds
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_out  <= RST_BIN;
      gray_out <= to_gray(RST_BIN);
      tc       <= 1'b0;
    end else if (load) begin
      bin_out  <= load_val;
      gray_out <= to_gray(load_val);
      tc       <= 1'b0;
    end else if (en) begin
      bin_out  <= bin_next;
      gray_out <= to_gray(bin_next);
      tc       <= tc_next;
    end
  end

`ifdef GRAY_CNT_CHECK_EN
  logic [N-1:0] prev_gray;
  logic         prev_clean;
  logic [N-1:0] gray_diff;
  logic         multi_flip;

  // More than one set bit in the XOR of consecutive Gray values is a step violation
  always_comb begin
    gray_diff  = gray_out ^ prev_gray;
    multi_flip = |(gray_diff & (gray_diff - ONE));
  end

  // prev_clean marks whether the edge that produced gray_out had no load or rst
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_gray  <= to_gray(RST_BIN);
      prev_clean <= 1'b0;
      err        <= 1'b0;
    end else begin
      prev_gray  <= gray_out;
      prev_clean <= ~load;
      if (prev_clean && multi_flip) begin
        err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Directed self-checking bench for gray_counter: one wrap-mode and one saturate-mode
// instance share the same stimulus; each test checks the instance it targets.
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] w_bin, w_gray, s_bin, s_gray;
  logic       w_tc, s_tc;
`ifdef GRAY_CNT_CHECK_EN
  logic       w_err, s_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_counter #(.N(4), .SATURATE(1'b0), .RST_VAL(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .bin_out(w_bin), .gray_out(w_gray), .tc(w_tc)
`ifdef GRAY_CNT_CHECK_EN
    , .err(w_err)
`endif
  );

  gray_counter #(.N(4), .SATURATE(1'b1), .RST_VAL(0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .bin_out(s_bin), .gray_out(s_gray), .tc(s_tc)
`ifdef GRAY_CNT_CHECK_EN
    , .err(s_err)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic l,
                       input logic [3:0] lv);
    rst = r; en = e; up_dn = u; load = l; load_val = lv;
  endtask

  task automatic test_reset();
    drive(1, 0, 1, 0, 4'h0);
    step();
    checks++;
    if ({w_bin, w_gray, w_tc} !== 9'b0000_0000_0) begin
      errors++;
      $display("FAIL reset_wrap: bin=%b gray=%b tc=%b, expected 0000 0000 0", w_bin, w_gray, w_tc);
    end
    checks++;
    if ({s_bin, s_gray, s_tc} !== 9'b0000_0000_0) begin
      errors++;
      $display("FAIL reset_sat: bin=%b gray=%b tc=%b, expected 0000 0000 0", s_bin, s_gray, s_tc);
    end
  endtask

  task automatic test_up_wrap();
    logic [3:0] gray_tbl [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                  4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                  4'b1010, 4'b1011, 4'b1001, 4'b1000};
    drive(0, 1, 1, 0, 4'h0);
    for (int i = 1; i <= 16; i++) begin
      logic [3:0] eb;
      logic       et;
      eb = 4'(i);
      et = (i == 16);
      step();
      checks++;
      if (w_bin !== eb || w_gray !== gray_tbl[eb] || w_tc !== et) begin
        errors++;
        $display("FAIL up_wrap[%0d]: bin=%b gray=%b tc=%b, expected %b %b %b",
                 i, w_bin, w_gray, w_tc, eb, gray_tbl[eb], et);
      end
    end
  endtask

  task automatic test_down_wrap();
    drive(0, 1, 0, 0, 4'h0);
    step();
    checks++;
    if (w_bin !== 4'b1111 || w_gray !== 4'b1000 || w_tc !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap: bin=%b gray=%b tc=%b, expected 1111 1000 1", w_bin, w_gray, w_tc);
    end
    step();
    checks++;
    if (w_bin !== 4'b1110 || w_gray !== 4'b1001 || w_tc !== 1'b0) begin
      errors++;
      $display("FAIL down_next: bin=%b gray=%b tc=%b, expected 1110 1001 0", w_bin, w_gray, w_tc);
    end
  endtask

  task automatic test_load_priority();
    drive(0, 1, 1, 1, 4'b0101);
    step();
    checks++;
    if (w_bin !== 4'b0101 || w_gray !== 4'b0111 || w_tc !== 1'b0) begin
      errors++;
      $display("FAIL load_wrap: bin=%b gray=%b tc=%b, expected 0101 0111 0", w_bin, w_gray, w_tc);
    end
    checks++;
    if (s_bin !== 4'b0101 || s_gray !== 4'b0111 || s_tc !== 1'b0) begin
      errors++;
      $display("FAIL load_sat: bin=%b gray=%b tc=%b, expected 0101 0111 0", s_bin, s_gray, s_tc);
    end
    drive(0, 0, 1, 0, 4'b1111);
    step();
    step();
    checks++;
    if (w_bin !== 4'b0101 || w_gray !== 4'b0111 || w_tc !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: bin=%b gray=%b tc=%b, expected 0101 0111 0", w_bin, w_gray, w_tc);
    end
  endtask

  task automatic test_saturate();
    drive(1, 0, 1, 0, 4'h0);
    step();
    drive(0, 0, 1, 1, 4'b1101);
    step();
    drive(0, 1, 1, 0, 4'h0);
    step();
    checks++;
    if (s_bin !== 4'b1110 || s_gray !== 4'b1001 || s_tc !== 1'b0) begin
      errors++;
      $display("FAIL sat_up1: bin=%b gray=%b tc=%b, expected 1110 1001 0", s_bin, s_gray, s_tc);
    end
    step();
    checks++;
    if (s_bin !== 4'b1111 || s_gray !== 4'b1000 || s_tc !== 1'b0) begin
      errors++;
      $display("FAIL sat_reach: bin=%b gray=%b tc=%b, expected 1111 1000 0", s_bin, s_gray, s_tc);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (s_bin !== 4'b1111 || s_gray !== 4'b1000 || s_tc !== 1'b1) begin
        errors++;
        $display("FAIL sat_hold[%0d]: bin=%b gray=%b tc=%b, expected 1111 1000 1", i, s_bin, s_gray, s_tc);
      end
    end
    up_dn = 1'b0;
    step();
    checks++;
    if (s_bin !== 4'b1110 || s_gray !== 4'b1001 || s_tc !== 1'b0) begin
      errors++;
      $display("FAIL sat_reverse: bin=%b gray=%b tc=%b, expected 1110 1001 0", s_bin, s_gray, s_tc);
    end
    drive(0, 0, 0, 1, 4'b0001);
    step();
    drive(0, 1, 0, 0, 4'h0);
    step();
    checks++;
    if (s_bin !== 4'b0000 || s_gray !== 4'b0000 || s_tc !== 1'b0) begin
      errors++;
      $display("FAIL sat_down0: bin=%b gray=%b tc=%b, expected 0000 0000 0", s_bin, s_gray, s_tc);
    end
    step();
    checks++;
    if (s_bin !== 4'b0000 || s_gray !== 4'b0000 || s_tc !== 1'b1) begin
      errors++;
      $display("FAIL sat_low_hold: bin=%b gray=%b tc=%b, expected 0000 0000 1", s_bin, s_gray, s_tc);
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 1, 1, 4'b1000);
    step();
    drive(0, 1, 1, 0, 4'h0);
    step();
    checks++;
    if (w_bin !== 4'b1001 || w_gray !== 4'b1101) begin
      errors++;
      $display("FAIL mid_count: bin=%b gray=%b, expected 1001 1101", w_bin, w_gray);
    end
    drive(1, 1, 1, 1, 4'b0110);
    step();
    checks++;
    if (w_bin !== 4'b0000 || w_gray !== 4'b0000 || w_tc !== 1'b0) begin
      errors++;
      $display("FAIL rst_over_load: bin=%b gray=%b tc=%b, expected 0000 0000 0", w_bin, w_gray, w_tc);
    end
    drive(0, 0, 1, 0, 4'h0);
    step();
    step();
    checks++;
    if (w_bin !== 4'b0000 || w_gray !== 4'b0000 || w_tc !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold: bin=%b gray=%b tc=%b, expected 0000 0000 0", w_bin, w_gray, w_tc);
    end
  endtask

  // Direction flips every 7 steps with a load in the middle; a small model tracks the count
  task automatic test_back_to_back();
    logic [3:0] eb, prev_g, eg;
    logic       et;
    drive(1, 0, 1, 0, 4'h0);
    step();
    eb = 4'h0;
    prev_g = 4'h0;
    for (int i = 0; i < 48; i++) begin
      logic u;
      u = ((i / 7) % 2) == 0;
      if (i == 24) begin
        drive(0, 1, u, 1, 4'b1011);
        step();
        eb = 4'b1011;
        prev_g = eb ^ (eb >> 1);
        continue;
      end
      drive(0, 1, u, 0, 4'h0);
      et = u ? (eb == 4'hF) : (eb == 4'h0);
      eb = u ? eb + 4'd1 : eb - 4'd1;
      eg = eb ^ (eb >> 1);
      step();
      checks++;
      if (w_bin !== eb || w_gray !== eg || w_tc !== et || $countones(w_gray ^ prev_g) != 1) begin
        errors++;
        $display("FAIL sweep[%0d]: bin=%b gray=%b tc=%b, expected %b %b %b (prev gray %b)",
                 i, w_bin, w_gray, w_tc, eb, eg, et, prev_g);
      end
      prev_g = eg;
    end
    drive(0, 0, 1, 0, 4'h0);
  endtask

`ifdef GRAY_CNT_CHECK_EN
  task automatic test_checker();
    step();
    checks++;
    if (w_err !== 1'b0 || s_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clean: err wrap=%b sat=%b, expected 0 0", w_err, s_err);
    end
    drive(0, 0, 1, 0, 4'h0);
    force u_wrap.gray_out = w_gray ^ 4'b0011;
    step();
    step();
    release u_wrap.gray_out;
    step();
    step();
    checks++;
    if (w_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%b, expected 1", w_err);
    end
    drive(1, 0, 1, 0, 4'h0);
    step();
    checks++;
    if (w_err !== 1'b0) begin
      errors++;
      $display("FAIL err_rst: err=%b, expected 0", w_err);
    end
    drive(0, 0, 1, 0, 4'h0);
  endtask
`endif

  initial begin
    drive(1, 0, 1, 0, 4'h0);
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_priority();
    test_saturate();
    test_reset_mid();
    test_back_to_back();
`ifdef GRAY_CNT_CHECK_EN
    test_checker();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
